// File: rtl/eight_bit_serial_subtractor_module_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width,
// FSM state encoding and a small sizing helper for the bit counter.
package eight_bit_serial_subtractor_module_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: waiting, shifting one bit per cycle, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width of a counter able to index every bit of a w-bit operand.
    // A 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/eight_bit_serial_subtractor_module_fa.sv
// One-bit full adder built from explicit gates; the subtractor uses a single
// instance of it, time-multiplexed over all operand bits.
module full_adder_gatelevel_module (
    input  logic a_bit,
    input  logic b_bit,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic prop;
    logic gen;
    logic prop_carry;

    // Propagate/generate form keeps the carry path to two gate levels.
    assign prop       = a_bit ^ b_bit;
    assign gen        = a_bit & b_bit;
    assign prop_carry = prop & c_in;
    assign sum        = prop ^ c_in;
    assign c_out      = gen | prop_carry;

endmodule

// File: rtl/eight_bit_serial_subtractor_module.sv
// Bit-serial subtractor: a - b computed as a + ~b + 1, LSB first, one bit per
// clock through a single full adder. Results and flags are published only when
// the last bit has been produced, so the outputs never show partial values.
module eight_bit_serial_subtractor_module
    import eight_bit_serial_subtractor_module_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Controller
    state_t state_reg;
    state_t state_next;
    logic   accept;      // start taken this cycle: latch operands
    logic   step;        // one bit is being produced this cycle
    logic   last_step;   // the bit being produced is the MSB

    // Datapath state
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;

    // Published results
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             overflow_reg;
    logic             zero_reg;

    // Per-bit datapath signals
    logic             a_bit;
    logic             b_bit_n;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] bit_sel;
    logic [WIDTH-1:0] res_next;
    logic             overflow_next;
    logic             zero_next;

    // Current operand bits; the subtrahend bit is inverted so the adder,
    // seeded with carry 1, performs two's-complement subtraction.
    assign a_bit   = a_reg[cnt_reg];
    assign b_bit_n = ~b_reg[cnt_reg];

    full_adder_gatelevel_module u_fa (
        .a_bit (a_bit),
        .b_bit (b_bit_n),
        .c_in  (carry_reg),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // Decode the bit counter into one-hot lane selects and merge the new sum
    // bit into the partially built result. res_next is therefore the complete
    // difference during the final bit cycle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res_lane
            assign bit_sel[gi]  = (cnt_reg == CNT_W'(gi));
            assign res_next[gi] = bit_sel[gi] ? fa_sum : res_reg[gi];
        end
    endgenerate

    // Signed overflow happens only when the operand signs differ and the
    // result sign disagrees with the minuend.
    assign overflow_next = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                           (res_next[WIDTH-1] ^ a_reg[WIDTH-1]);
    assign zero_next     = ~(|res_next);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control decode; busy/done are pure state decodes so a
    // reset clears them immediately.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here.
                busy = 1'b1;
                step = 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, serial result accumulation, carry chain and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            res_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b1;
        end else if (step) begin
            res_reg   <= res_next;
            carry_reg <= fa_cout;
            cnt_reg   <= cnt_reg + CNT_W'(1);
        end
    end

    // Publish the difference and all flags together on entry to DONE and
    // hold them until the next completed subtraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (last_step) begin
            diff_reg     <= res_next;
            borrow_reg   <= ~fa_cout;
            overflow_reg <= overflow_next;
            zero_reg     <= zero_next;
        end
    end

    assign diff     = diff_reg;
    assign borrow   = borrow_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;

endmodule
